// File: rtl/mips_pkg.sv
`default_nettype none
// +--------------------------------------------------------------+
// | mips_pkg: shared fetch-stage types and constants              |
// | rev 1.0                                                       |
// +--------------------------------------------------------------+
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/if_id_reg.sv
`default_nettype none
// +--------------------------------------------------------------+
// | if_id_reg: IF/ID pipeline register, flush > hold > load > bubble |
// | rev 1.0                                                       |
// +--------------------------------------------------------------+
module if_id_reg
    import mips_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              write_en,
    input  logic              load,
    input  logic [DATA_W-1:0] instr_in,
    input  logic [ADDR_W-1:0] pcplus4_in,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] pcplus4,
    output logic              valid
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr   <= DATA_W'(NOP_INSTR);
            pcplus4 <= '0;
            valid   <= 1'b0;
        end else if (flush) begin
            instr   <= DATA_W'(NOP_INSTR);
            pcplus4 <= '0;
            valid   <= 1'b0;
        end else if (!write_en) begin
            instr   <= instr;
            pcplus4 <= pcplus4;
            valid   <= valid;
        end else if (load) begin
            instr   <= instr_in;
            pcplus4 <= pcplus4_in;
            valid   <= 1'b1;
        end else begin
            instr   <= DATA_W'(NOP_INSTR);
            pcplus4 <= '0;
            valid   <= 1'b0;
        end
    end

endmodule : if_id_reg
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// +--------------------------------------------------------------+
// | if_stage: MIPS instruction fetch, PC + fetch FSM + IF/ID      |
// | rev 1.0                                                       |
// +--------------------------------------------------------------+
module if_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          ADDR_W   = 32,
    parameter int          DATA_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              PCWrite,
    input  logic              IF_ID_Write,
    input  logic              IF_Flush,
    input  logic [ADDR_W-1:0] branch_target,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              imem_ready,
    output logic [DATA_W-1:0] IF_ID_Instr,
    output logic [ADDR_W-1:0] IF_ID_PCPlus4,
    output logic              IF_ID_Valid,
    output logic              fetch_stall
);

    fetch_state_t      state, state_next;
    logic [ADDR_W-1:0] pc, pc_next;
    logic [ADDR_W-1:0] saved_target, saved_next;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] pc_plus4;
    logic              fetch_done;

    assign target     = branch_target & ~ADDR_W'(3);
    assign pc_plus4   = pc + ADDR_W'(4);
    assign fetch_done = (state == FETCH) && imem_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            pc           <= ADDR_W'(RESET_PC);
            saved_target <= '0;
        end else begin
            state        <= state_next;
            pc           <= pc_next;
            saved_target <= saved_next;
        end
    end

    always_comb begin
        state_next  = state;
        pc_next     = pc;
        saved_next  = saved_target;
        imem_req    = 1'b0;
        fetch_stall = 1'b0;
        case (state)
            IDLE: begin
                state_next = FETCH;
                if (IF_Flush) pc_next = target;
            end
            FETCH: begin
                imem_req    = 1'b1;
                fetch_stall = !imem_ready;
                if (IF_Flush) begin
                    if (imem_ready) begin
                        pc_next = target;
                    end else begin
                        saved_next = target;
                        state_next = DRAIN;
                    end
                end else if (PCWrite && imem_ready) begin
                    pc_next = pc_plus4;
                end
            end
            DRAIN: begin
                imem_req    = 1'b1;
                fetch_stall = 1'b1;
                if (IF_Flush) saved_next = target;
                // A flush arriving with the drained response still wins: newest target.
                if (imem_ready) begin
                    pc_next    = IF_Flush ? target : saved_target;
                    state_next = FETCH;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign imem_addr = pc;

    if_id_reg #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_if_id_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (IF_Flush),
        .write_en   (IF_ID_Write),
        .load       (fetch_done),
        .instr_in   (imem_rdata),
        .pcplus4_in (pc_plus4),
        .instr      (IF_ID_Instr),
        .pcplus4    (IF_ID_PCPlus4),
        .valid      (IF_ID_Valid)
    );

endmodule : if_stage
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// +--------------------------------------------------------------+
// | tb_if_stage: directed scoreboard bench for if_stage           |
// | rev 1.0                                                       |
// +--------------------------------------------------------------+
module tb_if_stage;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pcp4;
        logic        valid;
    } ifid_t;

    localparam int K_LOAD   = 0;
    localparam int K_HOLD   = 1;
    localparam int K_BUBBLE = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        PCWrite = 1'b1;
    logic        IF_ID_Write = 1'b1;
    logic        IF_Flush = 1'b0;
    logic [31:0] branch_target = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready = 1'b1;
    logic [31:0] IF_ID_Instr;
    logic [31:0] IF_ID_PCPlus4;
    logic        IF_ID_Valid;
    logic        fetch_stall;

    int    total = 0;
    int    bad   = 0;
    ifid_t sb_q[$];
    ifid_t last_push = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h8C00_1234;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    always #5 clk = ~clk;

    if_stage #(
        .RESET_PC (32'h0000_0000),
        .ADDR_W   (32),
        .DATA_W   (32)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .PCWrite       (PCWrite),
        .IF_ID_Write   (IF_ID_Write),
        .IF_Flush      (IF_Flush),
        .branch_target (branch_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .imem_ready    (imem_ready),
        .IF_ID_Instr   (IF_ID_Instr),
        .IF_ID_PCPlus4 (IF_ID_PCPlus4),
        .IF_ID_Valid   (IF_ID_Valid),
        .fetch_stall   (fetch_stall)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req"},   32'(imem_req),    32'd0);
        chk({tag, "_stall"}, 32'(fetch_stall), 32'd0);
        chk({tag, "_valid"}, 32'(IF_ID_Valid), 32'd0);
        chk({tag, "_instr"}, IF_ID_Instr,      32'd0);
        chk({tag, "_pcp4"},  IF_ID_PCPlus4,    32'd0);
    endtask

    // One clock cycle: drive, check the fetch interface, predict and check IF/ID.
    task automatic step(input logic pcw, input logic ifw, input logic fl,
                        input logic [31:0] tgt, input logic rdy,
                        input logic exp_req, input logic [31:0] exp_addr,
                        input logic exp_stall, input int kind);
        ifid_t e;
        ifid_t got;
        @(negedge clk);
        PCWrite = pcw; IF_ID_Write = ifw; IF_Flush = fl;
        branch_target = tgt; imem_ready = rdy;
        #1;
        chk("req",   32'(imem_req),    32'(exp_req));
        chk("addr",  imem_addr,        exp_addr);
        chk("stall", 32'(fetch_stall), 32'(exp_stall));
        case (kind)
            K_LOAD:  e = '{instr: mem_word(exp_addr), pcp4: exp_addr + 32'd4, valid: 1'b1};
            K_HOLD:  e = last_push;
            default: e = '{instr: 32'd0, pcp4: 32'd0, valid: 1'b0};
        endcase
        sb_q.push_back(e);
        last_push = e;
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            got = sb_q.pop_front();
            chk("ifid_valid", 32'(IF_ID_Valid), 32'(got.valid));
            chk("ifid_instr", IF_ID_Instr, got.instr);
            if (got.valid) chk("ifid_pcp4", IF_ID_PCPlus4, got.pcp4);
        end
    endtask

    initial begin
        #2;
        check_reset_outputs("reset");
        @(posedge clk); #2 rst_n = 1'b1;

        step(1, 1, 0, 32'h0, 1, 0, 32'h0000_0000, 0, K_BUBBLE);
        for (int a = 0; a < 32'h10; a += 4)
            step(1, 1, 0, 32'h0, 1, 1, 32'(a), 0, K_LOAD);

        // load-use stall at 0x10
        step(0, 0, 0, 32'h0, 1, 1, 32'h0000_0010, 0, K_HOLD);
        for (int a = 32'h10; a < 32'h20; a += 4)
            step(1, 1, 0, 32'h0, 1, 1, 32'(a), 0, K_LOAD);

        // zero-wait branch: low bits of target dropped
        step(1, 1, 1, 32'h0000_0103, 1, 1, 32'h0000_0020, 0, K_BUBBLE);
        step(1, 1, 0, 32'h0,         1, 1, 32'h0000_0100, 0, K_LOAD);
        // flush together with PCWrite=0: flush wins
        step(0, 1, 1, 32'h0000_0040, 1, 1, 32'h0000_0104, 0, K_BUBBLE);

        // flush during memory wait at 0x40
        step(1, 1, 1, 32'h0000_0080, 0, 1, 32'h0000_0040, 1, K_BUBBLE);
        step(1, 1, 0, 32'h0,         0, 1, 32'h0000_0040, 1, K_BUBBLE);
        step(1, 1, 0, 32'h0,         0, 1, 32'h0000_0040, 1, K_BUBBLE);
        step(1, 1, 0, 32'h0,         1, 1, 32'h0000_0040, 1, K_BUBBLE);
        step(1, 1, 0, 32'h0,         1, 1, 32'h0000_0080, 0, K_LOAD);

        // double flush in DRAIN: newest target wins
        step(1, 1, 1, 32'h0000_0080, 0, 1, 32'h0000_0084, 1, K_BUBBLE);
        step(1, 1, 1, 32'h0000_00C0, 0, 1, 32'h0000_0084, 1, K_BUBBLE);
        step(1, 1, 0, 32'h0,         1, 1, 32'h0000_0084, 1, K_BUBBLE);
        step(1, 1, 0, 32'h0,         1, 1, 32'h0000_00C0, 0, K_LOAD);

        // PC wrap at the top of the address space
        step(1, 1, 1, 32'hFFFF_FFFF, 1, 1, 32'h0000_00C4, 0, K_BUBBLE);
        step(1, 1, 0, 32'h0,         1, 1, 32'hFFFF_FFFC, 0, K_LOAD);
        step(1, 1, 0, 32'h0,         1, 1, 32'h0000_0000, 0, K_LOAD);

        // asynchronous reset in the middle of a memory wait at 0x4
        @(negedge clk);
        imem_ready = 1'b0;
        #1;
        chk("wait_req",   32'(imem_req),    32'd1);
        chk("wait_stall", 32'(fetch_stall), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        chk("async_rst_pc", imem_addr, 32'h0);
        @(posedge clk); #2 rst_n = 1'b1;
        imem_ready = 1'b1;
        last_push = '0;
        step(1, 1, 0, 32'h0, 1, 0, 32'h0000_0000, 0, K_BUBBLE);
        step(1, 1, 0, 32'h0, 1, 1, 32'h0000_0000, 0, K_LOAD);
        step(1, 1, 0, 32'h0, 1, 1, 32'h0000_0004, 0, K_LOAD);

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

endmodule : tb_if_stage
`default_nettype wire
